// File: rtl/fft_result_reader_if.sv
// Stream bundle for the FFT result reader: bit-reversed input words in,
// natural-order words out, each side with its own valid/ready handshake.
interface fft_result_reader_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic                  out_last;

    // Upstream producer plus downstream consumer, as seen by whoever drives the reader
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The reader itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fft_result_reader.sv
// FFT result reader: collects one frame of bit-reversed FFT results into a
// single buffer, then replays the frame in natural index order through a
// one-word output register. Fill and drain never overlap.
module fft_result_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int FFT_POINTS = 1024
) (
    input  logic                clk,
    input  logic                rst,
    fft_result_reader_if.slave  bus,
    output logic                frame_done,
    output logic [15:0]         frame_count
);
    localparam int LOG2 = $clog2(FFT_POINTS);
    localparam logic [LOG2-1:0] LAST_IDX = LOG2'(FFT_POINTS - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t                state;
    logic [LOG2-1:0]       wr_cnt;
    logic [LOG2-1:0]       rd_cnt;
    logic [DATA_WIDTH-1:0] mem [FFT_POINTS];
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  in_fire;
    logic                  out_fire;

    // Reverse the index bits so a bit-reversed arrival lands at its natural slot
    function automatic logic [LOG2-1:0] bitrev(input logic [LOG2-1:0] v);
        logic [LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < LOG2; i++) begin
            r[i] = v[LOG2-1-i];
        end
        return r;
    endfunction

    // in_ready is only high in FILL, so an input handshake implies FILL
    assign in_fire  = bus.in_valid && in_ready_q;
    assign out_fire = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;

    // Frame buffer write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            mem[bitrev(wr_cnt)] <= bus.in_data;
        end
    end

    // Fill/drain sequencer with registered handshake outputs and frame bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FILL;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                FILL: begin
                    if (in_fire) begin
                        wr_cnt <= wr_cnt + LOG2'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state      <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire && out_last_q) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        rd_cnt      <= '0;
                        frame_count <= frame_count + 16'd1;
                        frame_done  <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state       <= FILL;
                    end else if (!out_valid_q || out_fire) begin
                        out_data_q  <= mem[rd_cnt];
                        out_valid_q <= 1'b1;
                        out_last_q  <= (rd_cnt == LAST_IDX);
                        rd_cnt      <= rd_cnt + LOG2'(1);
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fft_result_reader.sv
// Testbench for fft_result_reader with an 8-point frame: directed frames are
// fed in, hand-computed natural-order results are queued, and a monitor on the
// falling edge pops and compares every output handshake.
module tb_fft_result_reader;
    localparam int DW  = 16;
    localparam int PTS = 8;

    localparam logic [15:0] EXP_REORDER [8] = '{16'h10, 16'h14, 16'h12, 16'h16, 16'h11, 16'h15, 16'h13, 16'h17};
    localparam logic [15:0] EXP_GAPS    [8] = '{16'hA0, 16'hA4, 16'hA2, 16'hA6, 16'hA1, 16'hA5, 16'hA3, 16'hA7};
    localparam logic [15:0] EXP_B2B_1   [8] = '{16'h00, 16'h04, 16'h02, 16'h06, 16'h01, 16'h05, 16'h03, 16'h07};
    localparam logic [15:0] EXP_B2B_2   [8] = '{16'h08, 16'h0C, 16'h0A, 16'h0E, 16'h09, 16'h0D, 16'h0B, 16'h0F};
    localparam logic [15:0] EXP_AFTER   [8] = '{16'h20, 16'h24, 16'h22, 16'h26, 16'h21, 16'h25, 16'h23, 16'h27};
    localparam logic [15:0] EXP_ABORT   [8] = '{16'h30, 16'h34, 16'h32, 16'h36, 16'h31, 16'h35, 16'h33, 16'h37};

    logic        clk;
    logic        rst;
    logic        frame_done;
    logic [15:0] frame_count;

    fft_result_reader_if #(.DATA_WIDTH(DW)) bus ();

    fft_result_reader #(
        .DATA_WIDTH(DW),
        .FFT_POINTS(PTS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_data_q [$];
    bit          exp_last_q [$];
    int          exp_fc_q   [$];
    bit          expect_done = 1'b0;
    bit          held = 1'b0;
    logic [15:0] held_data;
    logic        held_last;
    bit          rand_ready = 1'b0;
    logic        ready_level = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a mismatch
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Feed one word, waiting (bounded) for in_ready; optionally idle one cycle after
    task automatic applyStimulus(input logic [15:0] d, input bit gap);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("in_accept_timeout", 32'(n < 200), 32'd1);
        @(posedge clk);
        #1;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic feedFrame(input logic [15:0] base, input bit gaps);
        for (int i = 0; i < PTS; i++) begin
            applyStimulus(base + 16'(i), gaps);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pushFrame(input logic [15:0] e [8], input int fc);
        for (int i = 0; i < PTS; i++) begin
            exp_data_q.push_back(e[i]);
            exp_last_q.push_back(i == PTS - 1);
        end
        exp_fc_q.push_back(fc);
    endtask

    task automatic flushScoreboard();
        exp_data_q.delete();
        exp_last_q.delete();
        exp_fc_q.delete();
        expect_done = 1'b0;
        held        = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((exp_data_q.size() != 0 || exp_fc_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_timeout", 32'(n < 500), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        flushScoreboard();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    // Downstream ready driver: constant level or a coin flip each cycle
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
        end
    end

    // Monitor: sampled on the falling edge, where a valid&&ready pair means a handshake at the next rise
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (expect_done) begin
                    checkOutput("frame_done_pulse", 32'(frame_done), 32'd1);
                    checkOutput("in_ready_at_done", 32'(bus.in_ready), 32'd1);
                    checkOutput("out_valid_after_last", 32'(bus.out_valid), 32'd0);
                    checkOutput("out_last_after_last", 32'(bus.out_last), 32'd0);
                    if (exp_fc_q.size() == 0) begin
                        checkOutput("unexpected_frame_end", 32'd1, 32'd0);
                    end else begin
                        checkOutput("frame_count", 32'(frame_count), 32'(exp_fc_q.pop_front()));
                    end
                    expect_done = 1'b0;
                end else if (frame_done) begin
                    checkOutput("spurious_frame_done", 32'(frame_done), 32'd0);
                end
                if (held) begin
                    checkOutput("stall_valid", 32'(bus.out_valid), 32'd1);
                    checkOutput("stall_data", 32'(bus.out_data), 32'(held_data));
                    checkOutput("stall_last", 32'(bus.out_last), 32'(held_last));
                end
                if (bus.out_valid) begin
                    checkOutput("in_ready_in_drain", 32'(bus.in_ready), 32'd0);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_data_q.size() == 0) begin
                        checkOutput("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        logic [15:0] ed;
                        bit          el;
                        ed = exp_data_q.pop_front();
                        el = exp_last_q.pop_front();
                        checkOutput("out_data", 32'(bus.out_data), 32'(ed));
                        checkOutput("out_last", 32'(bus.out_last), 32'(el));
                        if (el) expect_done = 1'b1;
                    end
                end
                held      = bus.out_valid && !bus.out_ready;
                held_data = bus.out_data;
                held_last = bus.out_last;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        #12;

        // 1. Asynchronous reset mid-cycle during a partial fill
        $display("[TB] Test 1: reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        applyStimulus(16'h55, 1'b0);
        applyStimulus(16'h56, 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_out_last", 32'(bus.out_last), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_frame_count", 32'(frame_count), 32'd0);
        doReset();
        checkOutput("in_ready_after_release", 32'(bus.in_ready), 32'd1);

        // 2. Reorder with out_ready high, plus first-output latency
        $display("[TB] Test 2: reorder");
        ready_level = 1'b1;
        pushFrame(EXP_REORDER, 1);
        feedFrame(16'h10, 1'b0);
        checkOutput("lat_valid_edge1", 32'(bus.out_valid), 32'd0);
        checkOutput("lat_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid_edge2", 32'(bus.out_valid), 32'd1);
        checkOutput("lat_first_data", 32'(bus.out_data), 32'h10);
        waitDrain();
        checkOutput("data_kept_idle", 32'(bus.out_data), 32'h17);

        // 3. Same frame under random backpressure
        $display("[TB] Test 3: backpressure");
        doReset();
        rand_ready = 1'b1;
        pushFrame(EXP_REORDER, 1);
        feedFrame(16'h10, 1'b0);
        waitDrain();
        rand_ready = 1'b0;

        // 4. Gapped input
        $display("[TB] Test 4: input gaps");
        doReset();
        pushFrame(EXP_GAPS, 1);
        feedFrame(16'hA0, 1'b1);
        waitDrain();

        // 5. in_valid held high across two frames
        $display("[TB] Test 5: back-to-back");
        doReset();
        pushFrame(EXP_B2B_1, 1);
        pushFrame(EXP_B2B_2, 2);
        for (int i = 0; i < 2 * PTS; i++) begin
            applyStimulus(16'(i), 1'b0);
        end
        bus.in_valid = 1'b0;
        waitDrain();

        // 6. Reset during drain, then a clean frame
        $display("[TB] Test 6: reset mid-drain");
        doReset();
        pushFrame(EXP_ABORT, 1);
        feedFrame(16'h30, 1'b0);
        n = 0;
        while (exp_data_q.size() > 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_wait_timeout", 32'(n < 100), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("abort_frame_count", 32'(frame_count), 32'd0);
        doReset();
        pushFrame(EXP_AFTER, 1);
        feedFrame(16'h20, 1'b0);
        waitDrain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
